banco_registro_param: RTL and testbench
=======================================

# banco_registro_param

Parametrised successor of the 8×4-bit two-read/one-write register bank. Width and depth are set by parameters. Read outputs are registered, and each read port reports whether its register has been written. A sequential clear engine re-initialises the whole bank one entry per cycle. The block sits in the datapath as the general-purpose operand store, read by two consumers and written by one producer.

## Interface
- DATA_W, 4, data width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
- INIT_VAL, 0, value loaded on reset and on clear, truncated to DATA_W
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- addrRa  in  ADDR_W  read port A address
- addrRb  in  ADDR_W  read port B address
- datOutRa  out  DATA_W  registered read data, port A
- datOutRb  out  DATA_W  registered read data, port B
- validA  out  1  register read on port A has been written since the last reset or clear
- validB  out  1  same, port B
- addrW  in  ADDR_W  write address
- datW  in  DATA_W  write data
- RegWrite  in  1  write enable
- clr  in  1  clear request, level-sampled in IDLE
- busy  out  1  clear engine active; writes are blocked
- clrDone  out  1  one-cycle pulse when a clear completes

## Operation
- Reset (rst=0, asynchronous):
  - every entry = INIT_VAL and every written flag = 0;
  - datOutRa = datOutRb = INIT_VAL; validA = validB = 0;
  - busy = 0, clrDone = 0, FSM = IDLE, clear counter = 0.
- Write: at a clk edge with RegWrite=1 and busy=0, set mem[addrW] <= datW and flag[addrW] <= 1. When busy=1, RegWrite is ignored with no side effects.
- Read: every edge, datOutRa <= mem[addrRa] and validA <= flag[addrRa]. Port B behaves the same on addrRb. Both ports are independent, and the same address may be read on both.
- FSM states:
  - IDLE: if clr=1, go to CLEAR, set cnt <= 0, busy <= 1.
  - CLEAR: each edge, mem[cnt] <= INIT_VAL, flag[cnt] <= 0, cnt <= cnt+1. When cnt = DEPTH-1, go to IDLE with busy <= 0 and clrDone <= 1 for one cycle.
  - clr is ignored while in CLEAR. If clr is still high on return to IDLE, a new clear starts on the next edge.
- During CLEAR, reads return current contents: entries not yet cleared keep their old data and flags.
- cnt is ADDR_W bits wide and wraps naturally. No arithmetic on data; datW is stored as-is.

## Timing
- Read latency is 1 cycle: an address applied before edge k appears on datOutRx after edge k.
- Write-to-read through memory: a write at edge k is visible on a read registered at edge k+1. Same-edge forwarding is described under Configuration.
- Clear sequence:
  - clr sampled at edge k: busy=1 after k;
  - entries 0..DEPTH-1 are cleared at edges k+1..k+DEPTH;
  - busy=0 and clrDone=1 after k+DEPTH; clrDone=0 after k+DEPTH+1.
  - Total is DEPTH+1 edges from request to a write being accepted again.
- Reset asserted mid-clear aborts it immediately. After release the bank is in IDLE with all entries = INIT_VAL and clrDone = 0.
- rst release is synchronised externally; the block assumes a clean deassertion.

## Configuration
- BANCO_BYPASS_EN defined: if a write is accepted at edge k with addrW == addrRa, then datOutRa <= datW and validA <= 1 at that same edge. Port B behaves the same. During CLEAR, a read of address cnt forwards INIT_VAL with valid 0.
- Undefined: no forwarding. A read of the address being written or cleared at edge k returns the pre-edge contents and flag.

## Test plan
- Reset then read: hold rst=0, release, read addrRa=0 and addrRb=7 -> datOutRa=datOutRb=0, validA=validB=0.
- Fill and dual-read: write mem[i]=15-i for i=0..7. Then set (addrRa,addrRb)=(i,7-i) for i=0..3 -> after 1 cycle, datOutRa=15-i, datOutRb=8+i, validA=validB=1.
- Same-edge write/read: addrW=addrRa=3, datW=9, with mem[3]=12 -> with BANCO_BYPASS_EN, datOutRa=9 after that edge; without it, datOutRa=12, then 9 one cycle later.
- Clear sequence: pulse clr for 1 cycle after filling the bank -> busy high for exactly 8 cycles, clrDone high for 1 cycle. RegWrite=1 to addr 2 during busy has no effect. Afterwards every address reads 0 with valid=0.
- Reset mid-clear: assert rst low 3 cycles into CLEAR -> busy=0 immediately, clrDone never pulses, and all 8 entries read 0 after release.
- Parameter sweep: DATA_W=8, ADDR_W=4, INIT_VAL=8'hA5 -> after reset all 16 entries read A5. Writing 8'h3C to addr 15 reads back 3C. Clear takes 16 busy cycles.

Source files
------------

// File: rtl/banco_registro_param.sv
// Parametrised 2-read/1-write register bank with registered reads, per-entry written flags
// and a sequential clear engine. Optional same-edge forwarding under `BANCO_BYPASS_EN.
module banco_registro_param #(
  parameter int          DATA_W   = 4,
  parameter int          ADDR_W   = 3,
  parameter int unsigned INIT_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addrRa,
  input  logic [ADDR_W-1:0] addrRb,
  output logic [DATA_W-1:0] datOutRa,
  output logic [DATA_W-1:0] datOutRb,
  output logic              validA,
  output logic              validB,
  input  logic [ADDR_W-1:0] addrW,
  input  logic [DATA_W-1:0] datW,
  input  logic              RegWrite,
  input  logic              clr,
  output logic              busy,
  output logic              clrDone,
  output logic              stateDbg
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] INIT_D = DATA_W'(INIT_VAL);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  flag;
  logic [ADDR_W-1:0] cnt;

  // Write handshake: the producer offers a write with RegWrite; it is accepted on the
  // edge where busy is low, and silently dropped (no state change) while busy is high.
  logic wrEn;
  assign wrEn     = RegWrite && !busy;
  assign stateDbg = (state == CLEAR);

  logic [DATA_W-1:0] nxtRa, nxtRb;
  logic              nxtVa, nxtVb;

  always_comb begin
    nxtRa = mem[addrRa];
    nxtVa = flag[addrRa];
    nxtRb = mem[addrRb];
    nxtVb = flag[addrRb];
`ifdef BANCO_BYPASS_EN
    // Writes and clears never coincide: a write needs busy low, a clear needs CLEAR.
    if (wrEn && addrW == addrRa) begin
      nxtRa = datW;
      nxtVa = 1'b1;
    end else if (state == CLEAR && cnt == addrRa) begin
      nxtRa = INIT_D;
      nxtVa = 1'b0;
    end
    if (wrEn && addrW == addrRb) begin
      nxtRb = datW;
      nxtVb = 1'b1;
    end else if (state == CLEAR && cnt == addrRb) begin
      nxtRb = INIT_D;
      nxtVb = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_D;
      flag     <= '0;
      datOutRa <= INIT_D;
      datOutRb <= INIT_D;
      validA   <= 1'b0;
      validB   <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      clrDone  <= 1'b0;
    end else begin
      datOutRa <= nxtRa;
      datOutRb <= nxtRb;
      validA   <= nxtVa;
      validB   <= nxtVb;
      clrDone  <= 1'b0;
      if (wrEn) begin
        mem[addrW]  <= datW;
        flag[addrW] <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          mem[cnt]  <= INIT_D;
          flag[cnt] <= 1'b0;
          cnt       <= cnt + ADDR_W'(1);
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            clrDone <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_banco_registro_param.sv
// Directed self-checking bench for banco_registro_param: default 8x4 instance plus a
// 16x8 instance with INIT_VAL=A5 for the parameter sweep.
module tb_banco_registro_param;

  logic       clk;
  logic       rst;
  logic [2:0] addrRa, addrRb, addrW;
  logic [3:0] datW;
  logic       RegWrite, clr;
  logic [3:0] datOutRa, datOutRb;
  logic       validA, validB, busy, clrDone, stateDbg;

  logic [3:0] bAddrRa, bAddrRb, bAddrW;
  logic [7:0] bDatW;
  logic       bRegWrite, bClr;
  logic [7:0] bDatOutRa, bDatOutRb;
  logic       bValidA, bValidB, bBusy, bClrDone, bStateDbg;

  int nCmp = 0;
  int nErr = 0;
  logic [3:0] exp_q[$];

  banco_registro_param u_dut (
    .clk(clk), .rst(rst), .addrRa(addrRa), .addrRb(addrRb),
    .datOutRa(datOutRa), .datOutRb(datOutRb), .validA(validA), .validB(validB),
    .addrW(addrW), .datW(datW), .RegWrite(RegWrite), .clr(clr),
    .busy(busy), .clrDone(clrDone), .stateDbg(stateDbg)
  );

  banco_registro_param #(.DATA_W(8), .ADDR_W(4), .INIT_VAL('hA5)) u_big (
    .clk(clk), .rst(rst), .addrRa(bAddrRa), .addrRb(bAddrRb),
    .datOutRa(bDatOutRa), .datOutRb(bDatOutRb), .validA(bValidA), .validB(bValidB),
    .addrW(bAddrW), .datW(bDatW), .RegWrite(bRegWrite), .clr(bClr),
    .busy(bBusy), .clrDone(bClrDone), .stateDbg(bStateDbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [3:0] d);
    addrW = a; datW = d; RegWrite = 1'b1;
    step();
    RegWrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    addrRa = '0; addrRb = '0; addrW = '0; datW = '0; RegWrite = 1'b0; clr = 1'b0;
    bAddrRa = '0; bAddrRb = '0; bAddrW = '0; bDatW = '0; bRegWrite = 1'b0; bClr = 1'b0;
    #3 rst = 1'b0;
    step(); step();
    nCmp++; if (busy !== 1'b0 || clrDone !== 1'b0 || stateDbg !== 1'b0) begin nErr++; $display("FAIL reset_ctrl: busy=%b clrDone=%b state=%b want 0 0 0", busy, clrDone, stateDbg); end
    rst = 1'b1;
    addrRa = 3'd0; addrRb = 3'd7;
    step();
    nCmp++; if (datOutRa !== 4'd0 || datOutRb !== 4'd0) begin nErr++; $display("FAIL reset_data: got %h %h want 0 0", datOutRa, datOutRb); end
    nCmp++; if (validA !== 1'b0 || validB !== 1'b0) begin nErr++; $display("FAIL reset_valid: got %b %b want 0 0", validA, validB); end
  endtask

  task automatic test_fill_dual_read();
    for (int i = 0; i < 8; i++) write_reg(3'(i), 4'(15 - i));
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(4'(15 - i));
      exp_q.push_back(4'(8 + i));
    end
    for (int i = 0; i < 4; i++) begin
      logic [3:0] ea, eb;
      addrRa = 3'(i); addrRb = 3'(7 - i);
      step();
      ea = exp_q.pop_front();
      eb = exp_q.pop_front();
      nCmp++; if (datOutRa !== ea || datOutRb !== eb) begin nErr++; $display("FAIL dual_read[%0d]: got %h %h want %h %h", i, datOutRa, datOutRb, ea, eb); end
      nCmp++; if (validA !== 1'b1 || validB !== 1'b1) begin nErr++; $display("FAIL dual_valid[%0d]: got %b %b want 1 1", i, validA, validB); end
    end
  endtask

  task automatic test_same_edge();
    logic [3:0] first;
`ifdef BANCO_BYPASS_EN
    first = 4'd9;
`else
    first = 4'd12;
`endif
    addrRa = 3'd3;
    write_reg(3'd3, 4'd9);
    nCmp++; if (datOutRa !== first || validA !== 1'b1) begin nErr++; $display("FAIL same_edge: got %h/%b want %h/1", datOutRa, validA, first); end
    step();
    nCmp++; if (datOutRa !== 4'd9) begin nErr++; $display("FAIL same_edge_next: got %h want 9", datOutRa); end
  endtask

  task automatic test_clear();
    int busyCnt, doneCnt, e;
    logic [3:0] eb;
    logic       evb;
`ifdef BANCO_BYPASS_EN
    eb = 4'd0; evb = 1'b0;
`else
    eb = 4'd15; evb = 1'b1;
`endif
    addrRa = 3'd7; addrRb = 3'd0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    nCmp++; if (busy !== 1'b1 || stateDbg !== 1'b1) begin nErr++; $display("FAIL clear_start: busy=%b state=%b want 1 1", busy, stateDbg); end
    addrW = 3'd2; datW = 4'd5; RegWrite = 1'b1;
    busyCnt = 1; doneCnt = 0; e = 0;
    while (busy === 1'b1 && e < 40) begin
      step();
      e++;
      if (busy === 1'b1) busyCnt++;
      if (clrDone === 1'b1) doneCnt++;
      if (e == 1) begin
        nCmp++; if (datOutRa !== 4'd8 || validA !== 1'b1) begin nErr++; $display("FAIL clear_uncleared: got %h/%b want 8/1", datOutRa, validA); end
        nCmp++; if (datOutRb !== eb || validB !== evb) begin nErr++; $display("FAIL clear_cnt_read: got %h/%b want %h/%b", datOutRb, validB, eb, evb); end
      end
    end
    RegWrite = 1'b0;
    nCmp++; if (clrDone !== 1'b1) begin nErr++; $display("FAIL clear_done_edge: got %b want 1", clrDone); end
    step();
    if (clrDone === 1'b1) doneCnt++;
    step();
    if (clrDone === 1'b1) doneCnt++;
    nCmp++; if (busyCnt !== 8) begin nErr++; $display("FAIL clear_busy_len: got %0d want 8", busyCnt); end
    nCmp++; if (doneCnt !== 1) begin nErr++; $display("FAIL clear_done_len: got %0d want 1", doneCnt); end
    for (int i = 0; i < 8; i++) begin
      addrRa = 3'(i); addrRb = 3'(7 - i);
      step();
      nCmp++; if (datOutRa !== 4'd0 || validA !== 1'b0 || datOutRb !== 4'd0 || validB !== 1'b0) begin nErr++; $display("FAIL clear_after[%0d]: got %h/%b %h/%b want 0/0 0/0", i, datOutRa, validA, datOutRb, validB); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int doneCnt;
    write_reg(3'd1, 4'd7);
    write_reg(3'd6, 4'd4);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    #1;
    nCmp++; if (busy !== 1'b0 || clrDone !== 1'b0 || stateDbg !== 1'b0) begin nErr++; $display("FAIL midclr_abort: busy=%b clrDone=%b state=%b want 0 0 0", busy, clrDone, stateDbg); end
    step();
    rst = 1'b1;
    doneCnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (clrDone === 1'b1 || busy === 1'b1) doneCnt++;
    end
    nCmp++; if (doneCnt !== 0) begin nErr++; $display("FAIL midclr_no_done: busy/clrDone seen %0d times want 0", doneCnt); end
    for (int i = 0; i < 8; i++) begin
      addrRa = 3'(i); addrRb = 3'(i);
      step();
      nCmp++; if (datOutRa !== 4'd0 || validA !== 1'b0 || datOutRb !== 4'd0 || validB !== 1'b0) begin nErr++; $display("FAIL midclr_read[%0d]: got %h/%b %h/%b want 0/0 0/0", i, datOutRa, validA, datOutRb, validB); end
    end
  endtask

  task automatic test_param_sweep();
    int busyCnt;
    for (int i = 0; i < 16; i++) begin
      bAddrRa = 4'(i); bAddrRb = 4'(15 - i);
      step();
      nCmp++; if (bDatOutRa !== 8'hA5 || bDatOutRb !== 8'hA5 || bValidA !== 1'b0 || bValidB !== 1'b0) begin nErr++; $display("FAIL big_init[%0d]: got %h/%b %h/%b want a5/0 a5/0", i, bDatOutRa, bValidA, bDatOutRb, bValidB); end
    end
    bAddrW = 4'd15; bDatW = 8'h3C; bRegWrite = 1'b1;
    step();
    bRegWrite = 1'b0;
    bAddrRa = 4'd15;
    step();
    nCmp++; if (bDatOutRa !== 8'h3C || bValidA !== 1'b1) begin nErr++; $display("FAIL big_write: got %h/%b want 3c/1", bDatOutRa, bValidA); end
    bClr = 1'b1;
    step();
    bClr = 1'b0;
    busyCnt = 0;
    for (int i = 0; i < 40 && bBusy === 1'b1; i++) begin
      busyCnt++;
      step();
    end
    nCmp++; if (busyCnt !== 16 || bClrDone !== 1'b1) begin nErr++; $display("FAIL big_clear_len: busy %0d cycles clrDone=%b want 16 1", busyCnt, bClrDone); end
    step();
    nCmp++; if (bDatOutRa !== 8'hA5 || bValidA !== 1'b0) begin nErr++; $display("FAIL big_clear_read: got %h/%b want a5/0", bDatOutRa, bValidA); end
  endtask

  initial begin
    test_reset();
    test_fill_dual_read();
    test_same_edge();
    test_clear();
    test_reset_mid_clear();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
